// File: rtl/dec_unbinder_seq.sv
// Sequential unbinder: inverse-rotates one bound HV per feature, one
// 2^k rotate stage per cycle, and tags the result with its feature index.
// Ports: clk/nrst, start_decoding, in_valid/in_ready/bound_hv/bind_shift,
//        out_valid/out_ready/level_hv/feat_idx, frame_done.
module dec_unbinder_seq #(
  parameter int HV_DIM = 2048,
  parameter int NUM_FEATURES = 6,
  localparam int SHW = $clog2(HV_DIM),
  localparam int IDXW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_decoding,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HV_DIM-1:0] bound_hv,
  input  logic [SHW-1:0]    bind_shift,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HV_DIM-1:0] level_hv,
  output logic [IDXW-1:0]   feat_idx,
  output logic              frame_done
);

  localparam int STW = (SHW > 1) ? $clog2(SHW) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    ROTATE,
    OUTPUT
  } state_e;

  state_e            state_q, state_d;
  logic [HV_DIM-1:0] hv_q, hv_d;
  logic [SHW-1:0]    sh_q, sh_d;
  logic [STW-1:0]    stage_q, stage_d;
  logic [IDXW-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;

  // Right-rotate by 2^k: level[j] = bound[j + 2^k].
  logic [HV_DIM-1:0] rot_stage [SHW];

  for (genvar k = 0; k < SHW; k++) begin : g_rot
    assign rot_stage[k] = {hv_q[(2**k)-1:0],
                           hv_q[HV_DIM-1:(2**k)]};
  end

  always_comb begin
    state_d = state_q;
    hv_d    = hv_q;
    sh_d    = sh_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    // Start overrides everything: abort, restart, or open a frame.
    if (start_decoding) begin
      state_d = ACCEPT;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ACCEPT: begin
          if (in_valid) begin
            hv_d    = bound_hv;
            sh_d    = bind_shift;
            stage_d = '0;
            state_d = ROTATE;
          end
        end
        ROTATE: begin
          if (sh_q[stage_q]) hv_d = rot_stage[stage_q];
          if (stage_q == STW'(SHW - 1)) state_d = OUTPUT;
          else stage_d = stage_q + 1'b1;
        end
        OUTPUT: begin
          if (out_ready) begin
            if (cnt_q == IDXW'(NUM_FEATURES - 1)) begin
              cnt_d   = '0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              cnt_d   = cnt_q + 1'b1;
              state_d = ACCEPT;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      hv_q    <= '0;
      sh_q    <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hv_q    <= hv_d;
      sh_q    <= sh_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign in_ready   = (state_q == ACCEPT);
  assign out_valid  = (state_q == OUTPUT);
  assign level_hv   = hv_q;
  assign feat_idx   = cnt_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_dec_unbinder_seq.sv
// Directed bench for dec_unbinder_seq, HV_DIM=16, NUM_FEATURES=3.
// Each task drives one scenario and compares against hand values.
module tb_dec_unbinder_seq;

  logic        clk;
  logic        nrst;
  logic        start_decoding;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bound_hv;
  logic [3:0]  bind_shift;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] level_hv;
  logic [1:0]  feat_idx;
  logic        frame_done;

  int checks;
  int errors;

  dec_unbinder_seq #(
    .HV_DIM(16),
    .NUM_FEATURES(3)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .start_decoding(start_decoding),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .bound_hv(bound_hv),
    .bind_shift(bind_shift),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level_hv(level_hv),
    .feat_idx(feat_idx),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_decoding = 1'b1;
    step();
    start_decoding = 1'b0;
  endtask

  // Capture one input, then count edges until out_valid rises.
  task automatic do_unbind(input logic [15:0] hv,
                           input logic [3:0] sh,
                           output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    bound_hv   = hv;
    bind_shift = sh;
    in_valid   = 1'b1;
    step();
    in_valid   = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    #3;
    checks++;
    if ({in_ready, out_valid, frame_done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000",
               {in_ready, out_valid, frame_done});
    end
    checks++;
    if ({level_hv, feat_idx} !== 18'h0) begin
      errors++;
      $display("FAIL reset_data got %h/%h exp 0/0", level_hv, feat_idx);
    end
    step();
    nrst = 1'b1;
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores got rdy %b vld %b exp 0 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_single();
    int lat;
    pulse_start();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready got %b exp 1", in_ready);
    end
    do_unbind(16'h0001, 4'd1, lat);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL single_lat got %0d exp 4", lat);
    end
    checks++;
    if (level_hv !== 16'h8000 || feat_idx !== 2'd0) begin
      errors++;
      $display("FAIL single_out got %h/%0d exp 8000/0",
               level_hv, feat_idx);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    logic ok;
    do_unbind(16'h00F0, 4'd5, lat);
    checks++;
    if (lat != 4 || level_hv !== 16'h8007 || feat_idx !== 2'd1) begin
      errors++;
      $display("FAIL multi_out got %h/%0d lat %0d exp 8007/1 lat 4",
               level_hv, feat_idx, lat);
    end
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (level_hv !== 16'h8007 || feat_idx !== 2'd1 ||
          out_valid !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL hold got %h/%0d vld %b rdy %b exp 8007/1 1 0",
               level_hv, feat_idx, out_valid, in_ready);
    end
    consume();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL release got rdy %b vld %b exp 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_zero_shift();
    int lat;
    do_unbind(16'hA5C3, 4'd0, lat);
    checks++;
    if (lat != 4 || level_hv !== 16'hA5C3 || feat_idx !== 2'd2) begin
      errors++;
      $display("FAIL zero_shift got %h/%0d lat %0d exp a5c3/2 lat 4",
               level_hv, feat_idx, lat);
    end
    consume();
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL done_f1 got %b exp 1", frame_done);
    end
  endtask

  task automatic test_full_frame();
    logic [15:0] hv  [3];
    logic [3:0]  sh  [3];
    logic [15:0] exp [3];
    int lat;
    hv[0] = 16'h0001; sh[0] = 4'd3;  exp[0] = 16'h2000;
    hv[1] = 16'h1234; sh[1] = 4'd7;  exp[1] = 16'h6824;
    hv[2] = 16'h8001; sh[2] = 4'd15; exp[2] = 16'h0003;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      do_unbind(hv[i], sh[i], lat);
      checks++;
      if (lat != 4 || level_hv !== exp[i] || feat_idx !== 2'(i)) begin
        errors++;
        $display("FAIL frame_%0d got %h/%0d lat %0d exp %h/%0d lat 4",
                 i, level_hv, feat_idx, lat, exp[i], i);
      end
      if (i < 2) begin
        consume();
        checks++;
        if (frame_done !== 1'b0) begin
          errors++;
          $display("FAIL early_done_%0d got %b exp 0", i, frame_done);
        end
      end
    end
    consume();
    checks++;
    if (frame_done !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse got d%b r%b v%b exp 1 0 0",
               frame_done, in_ready, out_valid);
    end
    step();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL done_width got %b exp 0", frame_done);
    end
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_idle got rdy %b vld %b exp 0 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    pulse_start();
    n = 0;
    bound_hv   = 16'hFFFF;
    bind_shift = 4'd1;
    in_valid   = 1'b1;
    step();
    in_valid   = 1'b0;
    step();
    step();
    nrst = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, frame_done} !== 3'b000 ||
        level_hv !== 16'h0 || feat_idx !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset got r%b v%b d%b %h/%0d exp all 0",
               in_ready, out_valid, frame_done, level_hv, feat_idx);
    end
    step();
    nrst = 1'b1;
    while (n < 6) begin
      step();
      n++;
    end
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_idle got rdy %b vld %b exp 0 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_abort();
    int lat;
    logic saw_done;
    saw_done = 1'b0;
    pulse_start();
    // start with a valid input in ACCEPT: start wins, no capture
    bound_hv = 16'h0001;
    bind_shift = 4'd0;
    in_valid = 1'b1;
    start_decoding = 1'b1;
    step();
    start_decoding = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_wins got rdy %b exp 1", in_ready);
    end
    do_unbind(16'h0001, 4'd1, lat);
    consume();
    do_unbind(16'h00F0, 4'd5, lat);
    checks++;
    if (out_valid !== 1'b1 || feat_idx !== 2'd1) begin
      errors++;
      $display("FAIL pre_abort got v%b idx %0d exp 1 1",
               out_valid, feat_idx);
    end
    pulse_start();
    if (frame_done) saw_done = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort got v%b r%b exp 0 1", out_valid, in_ready);
    end
    do_unbind(16'h0002, 4'd2, lat);
    if (frame_done) saw_done = 1'b1;
    checks++;
    if (level_hv !== 16'h8000 || feat_idx !== 2'd0 || lat != 4) begin
      errors++;
      $display("FAIL post_abort got %h/%0d lat %0d exp 8000/0 lat 4",
               level_hv, feat_idx, lat);
    end
    consume();
    if (frame_done) saw_done = 1'b1;
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_done got %b exp 0", saw_done);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    start_decoding = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    bound_hv = '0;
    bind_shift = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_zero_shift();
    test_full_frame();
    test_reset_mid();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_unbinder_seq.md
Name: dec_unbinder_seq

Overview:
Sequential unbinder for the decode path of the sparse HDC datapath. It undoes the encoder binder's circular permutation on one bound hypervector at a time, using a valid/ready stream. The block is the inverse end of the binding interface. It accepts one bound HV per feature, applies an inverse rotation by the per-feature bind shift, and returns the recovered level HV tagged with its feature index. It sits between the query HV buffer and the level item-memory similarity stage.

Parameters:
HV_DIM, 2048, hypervector width in bits; must be a power of two.
NUM_FEATURES, 6, bound HVs per decode frame.
SHW, $clog2(HV_DIM), shift width; also the number of rotate stages/cycles.
IDXW, $clog2(NUM_FEATURES), feature index width (min 1).

Ports:
clk  input  1  clock, rising edge
nrst  input  1  asynchronous active-low reset
start_decoding  input  1  single-cycle pulse; opens or restarts a frame
in_valid  input  1  bound HV and shift present
in_ready  output  1  block can capture an input this cycle
bound_hv  input  HV_DIM  bound (shifted) hypervector
bind_shift  input  SHW  shift the encoder used for this feature (SHIFTS entry, driven by the decode controller)
out_valid  output  1  level_hv/feat_idx valid
out_ready  input  1  downstream accepts
level_hv  output  HV_DIM  recovered (unbound) hypervector
feat_idx  output  IDXW  feature index of level_hv, 0..NUM_FEATURES-1
frame_done  output  1  one-cycle pulse after the last feature is delivered

Behaviour:
- Reset (async, nrst=0): state IDLE; in_ready, out_valid, frame_done = 0; level_hv, feat_idx, the internal shift register and the feature counter = 0. Reset mid-operation discards all work.
- Unbind function: level_hv[j] = bound_hv[(j + bind_shift) mod HV_DIM] for all j.
- FSM states:
  - IDLE: in_ready=0. start_decoding moves the FSM to ACCEPT and sets the counter to 0.
  - ACCEPT: in_ready=1. On in_valid&&in_ready, capture bound_hv and bind_shift at the accepting edge E0 and go to ROTATE with stage=0.
  - ROTATE: in_ready=0. At edge E(k+1), if shift bit k is set, the register rotates by 2^k positions in the unbind direction. Otherwise it holds. After stage SHW-1 at edge E_SHW, go to OUTPUT.
  - OUTPUT: out_valid=1. level_hv = the register; feat_idx = the counter.
- Latency: out_valid is high in the cycle after E_SHW, so SHW cycles after capture, regardless of shift value. shift=0 still takes SHW cycles.
- Output handshake: level_hv and feat_idx hold stable while out_valid && !out_ready. On out_valid && out_ready:
  - Not last feature: counter+1, go to ACCEPT.
  - Last feature (counter == NUM_FEATURES-1): frame_done=1 for exactly the next cycle; counter is cleared; go to IDLE.
- Throughput: at most one HV per SHW+2 cycles. No input buffering.
- start_decoding in any non-IDLE state aborts the frame:
  - Next cycle: out_valid=0, counter=0, state ACCEPT.
  - The in-flight HV is dropped.
  - No frame_done is generated for the aborted frame.
- Simultaneous start_decoding and an in_valid handshake in ACCEPT: start wins and the input is not captured.
- Simultaneous start_decoding and an out handshake on the last feature: the handshake completes, frame_done is suppressed, and the FSM enters ACCEPT with counter 0.
- in_valid while in_ready=0 is ignored. The upstream must hold its data until the handshake.

Test Plan:
All scenarios use HV_DIM=16 (SHW=4) and NUM_FEATURES=3.
- Single bit: start, bound_hv=16'h0001, bind_shift=1 -> level_hv=16'h8000, feat_idx=0, out_valid rising 4 cycles after the capture edge.
- Multi-bit / zero shift: bound_hv=16'h00F0, shift=5 -> 16'h8007. Then bound_hv=16'hA5C3, shift=0 -> 16'hA5C3 with the same 4-cycle latency.
- Backpressure: hold out_ready=0 for 5 cycles on output 16'h8007 -> level_hv and feat_idx stable, out_valid held, in_ready=0 throughout. Release -> ACCEPT next cycle.
- Full frame: three inputs with shifts 3, 7, 15 -> feat_idx sequence 0, 1, 2; frame_done high exactly one cycle after the 3rd out handshake; then IDLE with in_ready=0 until the next start_decoding.
- Reset mid-rotate: drop nrst two cycles after capture -> out_valid, in_ready, level_hv, feat_idx, frame_done all 0 immediately. After release, IDLE.
- Abort: start_decoding while in OUTPUT for feature 1 -> out_valid 0 next cycle, in_ready 1, next output has feat_idx=0, no frame_done pulse.
